// File: rtl/dtcm_responder_if.sv
// Request/response bus between the execute stage's dmem port and the DTCM responder.
interface dtcm_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_error;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_error
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_error
  );
endinterface

// File: rtl/dtcm_responder.sv
// Data TCM with a programmable wait-state responder on the dmem request bus.
// Optional out-of-range fault reporting is enabled by defining DTCM_RANGE_CHECK_EN.
module dtcm_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst,
  dtcm_responder_if.slave mem_io
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0] WaitCnt = 4'(WAIT_STATES);

  logic [31:0]   mem_q [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   req_off;
  logic [AW-1:0] req_idx;
  logic          req_we;
  logic          req_err;

  logic [AW-1:0] rd_idx;
  logic          rd_we;
  logic          rd_err;

  assign req_off = {mem_io.mem_addr[31:2], 2'b00} - BASE_ADDR;
  assign req_idx = req_off[AW+1:2];
  assign req_we  = (mem_io.mem_wstrb != 4'b0000) & ~mem_io.mem_instr;

`ifdef DTCM_RANGE_CHECK_EN
  assign req_err = {32'd0, req_off} >= (64'(DEPTH) << 2);
`else
  assign req_err = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_io.mem_addr[1:0], req_off};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    we_d    = we_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (mem_io.mem_valid) begin
          idx_d   = req_idx;
          wdata_d = mem_io.mem_wdata;
          wstrb_d = mem_io.mem_wstrb;
          we_d    = req_we;
          err_d   = req_err;
          cnt_d   = WaitCnt;
          state_d = (WaitCnt != 4'd0) ? StWait : StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the read happens on the accept edge, before the request is latched.
  assign rd_idx = (state_q == StIdle) ? req_idx : idx_q;
  assign rd_we  = (state_q == StIdle) ? req_we  : we_q;
  assign rd_err = (state_q == StIdle) ? req_err : err_q;

  always_comb begin
    rdata_d = rdata_q;
    if (state_d == StResp && state_q != StResp) begin
      rdata_d = (rd_we || rd_err) ? 32'd0 : mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Write commits on the edge closing RESP; an async reset clears state_q first, aborting it.
  always_ff @(posedge clk) begin
    if (state_q == StResp && we_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign mem_io.mem_ready = (state_q == StResp);
  assign mem_io.mem_rdata = rdata_q;
  assign mem_io.mem_error = (state_q == StResp) & err_q;

endmodule
